player_hazard_checker: RTL and testbench



---
 rtl/player_hazard_checker_pkg.sv | 25 ++
 rtl/player_hazard_checker.sv | 166 ++++++++++++++++
 tb/tb_player_hazard_checker.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/player_hazard_checker_pkg.sv
// Shared game definitions: checker state encoding and a saturating coordinate helper.
package player_hazard_checker_pkg;

  // Checker sequencing states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitRdy = 2'd1,
    StProbe   = 2'd2,
    StReport  = 2'd3
  } hazard_state_e;

  // Index of the final bounding-box corner probed in a frame.
  localparam logic [1:0] LastCorner = 2'd3;

  // base + extent, clamped to limit; the sum is formed at full int width so it cannot wrap
  // for any on-screen coordinate. Also used by the renderer for sprite extents.
  function automatic int unsigned clamp_add(input int unsigned base,
                                            input int unsigned extent,
                                            input int unsigned limit);
    int unsigned sum;
    sum = base + extent;
    return (sum > limit) ? limit : sum;
  endfunction

endpackage

// File: rtl/player_hazard_checker.sv
// Per-frame player collision checker: probes the four bounding-box corners against the
// safe-zone map, one corner per cycle, and tracks consecutive unsafe frames to raise death.
module player_hazard_checker
  import player_hazard_checker_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = 800,
  parameter int unsigned SCREEN_HEIGHT = 600,
  parameter int unsigned PLAYER_W      = 20,
  parameter int unsigned PLAYER_H      = 20,
  parameter int unsigned GRACE_FRAMES  = 3,
  localparam int unsigned XW           = $clog2(SCREEN_WIDTH),
  localparam int unsigned YW           = $clog2(SCREEN_HEIGHT)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_frame_tick,
  input  logic [XW-1:0] i_px,
  input  logic [YW-1:0] i_py,
  input  logic          i_clear,
  input  logic          i_zone_rdy,
  output logic [XW-1:0] o_qx,
  output logic [YW-1:0] o_qy,
  input  logic          i_is_safe,
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_unsafe,
  output logic          o_death,
  output logic          o_overrun
);

  localparam int unsigned CW          = $clog2(GRACE_FRAMES + 1);
  localparam logic [CW-1:0] GraceMax  = CW'(GRACE_FRAMES);
  localparam logic [CW-1:0] GraceLast = CW'(GRACE_FRAMES - 1);

  hazard_state_e r_state;
  logic [XW-1:0] r_px;
  logic [YW-1:0] r_py;
  logic [XW-1:0] r_qx;
  logic [YW-1:0] r_qy;
  logic [1:0]    r_k;
  logic          r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          r_unsafe;
  logic          r_death;
  logic          r_overrun;

  logic [XW-1:0] w_x1;
  logic [YW-1:0] w_y1;
  logic [1:0]    w_k_next;
  logic [XW-1:0] w_cx;
  logic [YW-1:0] w_cy;
  logic          w_acc_next;
  logic [CW-1:0] w_cnt_eff;
  logic [CW-1:0] w_cnt_sat;
  logic          w_death;
  logic          w_tick_ignored;

  // Far-corner coordinates, next-corner selection and report-side arithmetic.
  always_comb begin
    w_x1     = XW'(clamp_add(32'(r_px), PLAYER_W - 1, SCREEN_WIDTH - 1));
    w_y1     = YW'(clamp_add(32'(r_py), PLAYER_H - 1, SCREEN_HEIGHT - 1));
    w_k_next = r_k + 2'd1;
    // Bit 0 of the corner index picks the right edge, bit 1 the bottom edge.
    w_cx     = w_k_next[0] ? w_x1 : r_px;
    w_cy     = w_k_next[1] ? w_y1 : r_py;
    w_acc_next = r_acc | ~i_is_safe;
    // A clear landing in the final probe cycle takes effect before the death decision.
    w_cnt_eff  = i_clear ? '0 : r_cnt;
    w_death    = w_acc_next && (w_cnt_eff == GraceLast);
    w_cnt_sat  = (r_cnt == GraceMax) ? r_cnt : r_cnt + CW'(1);
    w_tick_ignored = i_frame_tick && (r_state != StIdle);
  end

  // Sequencer with registered query coordinates, result, death pulse and overrun flag.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state   <= StIdle;
      r_px      <= '0;
      r_py      <= '0;
      r_qx      <= '0;
      r_qy      <= '0;
      r_k       <= '0;
      r_acc     <= 1'b0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_unsafe  <= 1'b0;
      r_death   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_death <= 1'b0;

      // A dropped tick outranks a simultaneous clear.
      if (w_tick_ignored) begin
        r_overrun <= 1'b1;
      end else if (i_clear) begin
        r_overrun <= 1'b0;
      end

      // In the report cycle the report's own counter update has priority over clear.
      if (i_clear && (r_state != StReport)) begin
        r_cnt <= '0;
      end

      case (r_state)
        StIdle: begin
          if (i_frame_tick) begin
            r_px <= i_px;
            r_py <= i_py;
            if (i_zone_rdy) begin
              r_state <= StProbe;
              r_k     <= '0;
              r_acc   <= 1'b0;
              r_qx    <= i_px;
              r_qy    <= i_py;
            end else begin
              r_state <= StWaitRdy;
            end
          end
        end
        StWaitRdy: begin
          if (i_zone_rdy) begin
            r_state <= StProbe;
            r_k     <= '0;
            r_acc   <= 1'b0;
            r_qx    <= r_px;
            r_qy    <= r_py;
          end
        end
        StProbe: begin
          if (!i_zone_rdy) begin
            // Map went stale: drop this sample and redo all four corners later.
            r_state <= StWaitRdy;
            r_acc   <= 1'b0;
          end else if (r_k == LastCorner) begin
            r_state  <= StReport;
            r_acc    <= w_acc_next;
            r_valid  <= 1'b1;
            r_unsafe <= w_acc_next;
            r_death  <= w_death;
          end else begin
            r_acc <= w_acc_next;
            r_k   <= w_k_next;
            r_qx  <= w_cx;
            r_qy  <= w_cy;
          end
        end
        StReport: begin
          r_state <= StIdle;
          r_cnt   <= r_acc ? w_cnt_sat : '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_qx      = r_qx;
  assign o_qy      = r_qy;
  assign o_busy    = (r_state != StIdle);
  assign o_valid   = r_valid;
  assign o_unsafe  = r_unsafe;
  assign o_death   = r_death;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_player_hazard_checker.sv
// Self-checking bench: directed frames against a behavioural safe-zone map stub; expected
// results are queued at tick time and popped by an independent monitor on o_valid.
module tb_player_hazard_checker;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       i_frame_tick;
  logic [9:0] i_px;
  logic [9:0] i_py;
  logic       i_clear;
  logic       i_zone_rdy;
  logic [9:0] o_qx;
  logic [9:0] o_qy;
  logic       i_is_safe;
  logic       o_busy;
  logic       o_valid;
  logic       o_unsafe;
  logic       o_death;
  logic       o_overrun;

  int map_mode;
  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];  // {unsafe, death}

  always #5 clk = ~clk;

  player_hazard_checker dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_frame_tick (i_frame_tick),
    .i_px         (i_px),
    .i_py         (i_py),
    .i_clear      (i_clear),
    .i_zone_rdy   (i_zone_rdy),
    .o_qx         (o_qx),
    .o_qy         (o_qy),
    .i_is_safe    (i_is_safe),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_unsafe     (o_unsafe),
    .o_death      (o_death),
    .o_overrun    (o_overrun)
  );

  // Map stub: 0 = all safe, 1 = unsafe for x >= 110, 2 = unsafe for x >= 210.
  always_comb begin
    i_is_safe = 1'b1;
    if (map_mode == 1) i_is_safe = (o_qx < 10'd110);
    if (map_mode == 2) i_is_safe = (o_qx < 10'd210);
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Monitor: every o_valid consumes one expected result.
  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(o_valid), 0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("unsafe", 32'(o_unsafe), 32'(e[1]));
        check("death", 32'(o_death), 32'(e[0]));
      end
    end
    if (o_death && !o_valid) check("death_without_valid", 32'(o_valid), 1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of the k=0 probe cycle; ends at the start of the cycle after REPORT.
  task automatic probe_and_report(input int x0, input int y0, input int x1, input int y1);
    int ex[4];
    int ey[4];
    ex = '{x0, x1, x0, x1};
    ey = '{y0, y0, y1, y1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("qx_k%0d", k), 32'(o_qx), 32'(ex[k]));
      check($sformatf("qy_k%0d", k), 32'(o_qy), 32'(ey[k]));
      cyc();
    end
    @(negedge clk);
    check("valid_at_report", 32'(o_valid), 1);
    cyc();
  endtask

  task automatic run_frame(input int px, input int py, input int x1, input int y1,
                           input logic u, input logic d);
    cyc();
    i_frame_tick = 1'b1;
    i_px = 10'(px);
    i_py = 10'(py);
    exp_q.push_back({u, d});
    cyc();
    i_frame_tick = 1'b0;
    probe_and_report(px, py, x1, y1);
  endtask

  initial begin
    arst_n = 1'b0; i_frame_tick = 1'b0; i_px = '0; i_py = '0;
    i_clear = 1'b0; i_zone_rdy = 1'b1; map_mode = 0;
    repeat (3) cyc();
    @(negedge clk);
    check("reset_outputs", 32'({o_qx, o_qy, o_busy, o_valid, o_unsafe, o_death, o_overrun}), 0);
    cyc();
    arst_n = 1'b1;

    // Basic safe frame, then an unsafe one (counter 1).
    run_frame(100, 100, 119, 119, 1'b0, 1'b0);
    map_mode = 1;
    run_frame(100, 100, 119, 119, 1'b1, 1'b0);
    map_mode = 0;
    run_frame(100, 100, 119, 119, 1'b0, 1'b0);

    // Grace window: death on the third unsafe frame only, then saturation.
    map_mode = 1;
    run_frame(100, 100, 119, 119, 1'b1, 1'b0);
    run_frame(100, 100, 119, 119, 1'b1, 1'b0);
    run_frame(100, 100, 119, 119, 1'b1, 1'b1);
    run_frame(100, 100, 119, 119, 1'b1, 1'b0);
    map_mode = 0;
    run_frame(100, 100, 119, 119, 1'b0, 1'b0);
    map_mode = 1;
    run_frame(100, 100, 119, 119, 1'b1, 1'b0);
    run_frame(100, 100, 119, 119, 1'b1, 1'b0);
    run_frame(100, 100, 119, 119, 1'b1, 1'b1);

    // Clamping at the screen edge.
    map_mode = 0;
    run_frame(790, 590, 799, 599, 1'b0, 1'b0);

    // Map not ready at tick: queries hold, busy, no result; ready at R -> k0 at R+1.
    cyc();
    i_zone_rdy = 1'b0; i_frame_tick = 1'b1; i_px = 10'd50; i_py = 10'd60;
    exp_q.push_back(2'b00);
    cyc();
    i_frame_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait_qx_held", 32'(o_qx), 799);
      check("wait_qy_held", 32'(o_qy), 599);
      check("wait_busy", 32'(o_busy), 1);
      check("wait_no_valid", 32'(o_valid), 0);
      cyc();
    end
    i_zone_rdy = 1'b1;
    cyc();
    probe_and_report(50, 60, 69, 79);

    // Ready drops during k=2 after an unsafe k=1 sample; restart on an all-safe map.
    map_mode = 2;
    cyc();
    i_frame_tick = 1'b1; i_px = 10'd200; i_py = 10'd300;
    exp_q.push_back(2'b00);
    cyc();
    i_frame_tick = 1'b0;
    @(negedge clk); check("abort_qx_k0", 32'(o_qx), 200);
    cyc();
    @(negedge clk); check("abort_qx_k1", 32'(o_qx), 219);
    cyc();
    i_zone_rdy = 1'b0;
    @(negedge clk); check("abort_qy_k2", 32'(o_qy), 319);
    cyc();
    map_mode = 0;
    @(negedge clk); check("abort_busy", 32'(o_busy), 1);
    check("abort_no_valid", 32'(o_valid), 0);
    cyc();
    i_zone_rdy = 1'b1;
    cyc();
    probe_and_report(200, 300, 219, 319);

    // Tick during probe: overrun set, result unaffected; clear drops overrun.
    map_mode = 1;
    cyc();
    i_frame_tick = 1'b1; i_px = 10'd100; i_py = 10'd100;
    exp_q.push_back(2'b10);
    cyc();
    i_frame_tick = 1'b0;
    @(negedge clk); check("ovr_qx_k0", 32'(o_qx), 100);
    cyc();
    i_frame_tick = 1'b1; i_px = 10'd300; i_py = 10'd300;
    @(negedge clk); check("ovr_qx_k1", 32'(o_qx), 119);
    cyc();
    i_frame_tick = 1'b0;
    @(negedge clk); check("overrun_set", 32'(o_overrun), 1);
    check("ovr_qy_k2", 32'(o_qy), 119);
    cyc();
    @(negedge clk); check("ovr_qx_k3", 32'(o_qx), 119);
    cyc();
    @(negedge clk); check("ovr_valid", 32'(o_valid), 1);
    cyc();
    cyc();
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    @(negedge clk); check("overrun_cleared", 32'(o_overrun), 0);

    // Clear coincident with an ignored tick: overrun stays set.
    cyc();
    i_frame_tick = 1'b1; i_px = 10'd100; i_py = 10'd100;
    exp_q.push_back(2'b10);
    cyc();
    i_frame_tick = 1'b0;
    cyc();
    i_frame_tick = 1'b1; i_clear = 1'b1;
    cyc();
    i_frame_tick = 1'b0; i_clear = 1'b0;
    @(negedge clk); check("overrun_set_wins", 32'(o_overrun), 1);
    cyc();
    cyc();
    @(negedge clk); check("clr_valid", 32'(o_valid), 1);
    cyc();
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;

    // Reset mid-probe aborts with no result.
    map_mode = 0;
    cyc();
    i_frame_tick = 1'b1; i_px = 10'd10; i_py = 10'd10;
    cyc();
    i_frame_tick = 1'b0;
    cyc();
    i_frame_tick = 1'b1;
    cyc();
    i_frame_tick = 1'b0; arst_n = 1'b0;
    cyc();
    arst_n = 1'b1;
    @(negedge clk);
    check("midreset_outputs",
          32'({o_qx, o_qy, o_busy, o_valid, o_unsafe, o_death, o_overrun}), 0);
    repeat (6) cyc();
    @(negedge clk); check("post_reset_idle", 32'(o_busy), 0);

    repeat (2) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
